// File: rtl/imem_host_port.sv
// Host-side controller for port A of the CPU instruction/data BRAM.
// Converts write/read/run/halt commands into port-A cycles, returns read
// data over a valid/ready response channel and drives the CPU reset.
module imem_host_port #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic              o_cpu_rstn,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_RUN   = 2'b10,
        OP_HALT  = 2'b11
    } op_t;

    // RD_LAT is at most 3, so two bits cover every legal count
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    state_t     state;
    logic [1:0] lat_cnt;
    op_t        op;

    assign op = op_t'(i_cmd_op);

    // Command FSM; every output is a register updated here
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            o_cmd_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_din   <= '0;
            o_cpu_rstn  <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        case (op)
                            OP_WRITE: begin
                                // writes are refused while the CPU owns the memory
                                if (o_cpu_rstn) begin
                                    o_err <= 1'b1;
                                end else begin
                                    state       <= WRITE;
                                    o_cmd_ready <= 1'b0;
                                    o_mem_en    <= 1'b1;
                                    o_mem_we    <= 1'b1;
                                    o_mem_addr  <= i_cmd_addr;
                                    o_mem_din   <= i_cmd_wdata;
                                end
                            end
                            OP_READ: begin
                                state       <= RD_WAIT;
                                o_cmd_ready <= 1'b0;
                                o_mem_en    <= 1'b1;
                                o_mem_we    <= 1'b0;
                                o_mem_addr  <= i_cmd_addr;
                                lat_cnt     <= '0;
                            end
                            OP_RUN: begin
                                o_cpu_rstn <= 1'b1;
                            end
                            OP_HALT: begin
                                o_cpu_rstn <= 1'b0;
                                o_err      <= 1'b0;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    o_mem_en    <= 1'b0;
                    o_mem_we    <= 1'b0;
                    o_cmd_ready <= 1'b1;
                    state       <= IDLE;
                end
                RD_WAIT: begin
                    o_mem_en <= 1'b0;
                    if (lat_cnt == LAT_LAST) begin
                        o_rsp_data  <= i_mem_dout;
                        o_rsp_valid <= 1'b1;
                        state       <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_host_port.sv
// Bench for imem_host_port: two instances (RD_LAT=1 and RD_LAT=3) share one
// command stream, each backed by its own BRAM model.
module tb_imem_host_port;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_ready;

    logic          ready1, rsp_valid1, en1, we1, cpu_rstn1, err1;
    logic [DW-1:0] rsp_data1, din1, dout1;
    logic [AW-1:0] addr1;
    logic          ready3, rsp_valid3, en3, we3, cpu_rstn3, err3;
    logic [DW-1:0] rsp_data3, din3, dout3;
    logic [AW-1:0] addr3;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [DW-1:0] ref_mem [512];
    bit            running = 1'b0;
    bit            err_m   = 1'b0;
    int            written [$];

    always #5 clk = ~clk;

    imem_host_port #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_cmd_valid(cmd_valid), .o_cmd_ready(ready1),
        .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data1),
        .o_mem_en(en1), .o_mem_we(we1), .o_mem_addr(addr1), .o_mem_din(din1),
        .i_mem_dout(dout1), .o_cpu_rstn(cpu_rstn1), .o_err(err1)
    );

    imem_host_port #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .i_clk(clk), .i_rstn(rstn), .i_cmd_valid(cmd_valid), .o_cmd_ready(ready3),
        .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data3),
        .o_mem_en(en3), .o_mem_we(we3), .o_mem_addr(addr3), .o_mem_din(din3),
        .i_mem_dout(dout3), .o_cpu_rstn(cpu_rstn3), .o_err(err3)
    );

    // BRAM models: read-first, output is zero unless a read was issued
    logic [DW-1:0] bram1 [512];
    logic [DW-1:0] bram3 [512];
    logic [DW-1:0] pipe1;
    logic [DW-1:0] pipe3 [3];

    always @(posedge clk) begin
        if (en1 && we1) bram1[addr1] <= din1;
        pipe1 <= (en1 && !we1) ? bram1[addr1] : '0;
    end

    always @(posedge clk) begin
        if (en3 && we3) bram3[addr3] <= din3;
        pipe3[0] <= (en3 && !we3) ? bram3[addr3] : '0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign dout1 = pipe1;
    assign dout3 = pipe3[2];

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(ready1 && ready3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!(ready1 && ready3)) begin
            fails++;
            $display("FAIL wait_idle: ready1=%0b ready3=%0b, required both 1", ready1, ready3);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_idle();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if (!running) begin
            if ({en1, we1, addr1, din1, ready1, cpu_rstn1, en3, we3} !== {1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b1, 1'b1}) begin
                fails++;
                $display("FAIL write_pulse: en=%0b we=%0b addr=%h din=%h rdy=%0b cpu=%0b, required 1 1 %h %h 0 0",
                         en1, we1, addr1, din1, ready1, cpu_rstn1, a, d);
            end
            ref_mem[a] = d;
            written.push_back(int'(a));
        end else begin
            err_m = 1'b1;
            if ({en1, we1, err1, ready1, en3, we3, err3} !== 7'b0011001) begin
                fails++;
                $display("FAIL write_running: en=%0b we=%0b err=%0b rdy=%0b, required 0 0 1 1", en1, we1, err1, ready1);
            end
        end
        @(negedge clk);
        tests++;
        if ({en1, we1, ready1, err1} !== {1'b0, 1'b0, 1'b1, err_m}) begin
            fails++;
            $display("FAIL write_end: en=%0b we=%0b rdy=%0b err=%0b, required 0 0 1 %0b", en1, we1, ready1, err1, err_m);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int lat1 = -1, lat3 = -1, cnt1 = 0, cnt3 = 0;
        logic [DW-1:0] d1 = '0, d3 = '0;
        rsp_ready = 1'b1;
        wait_idle();
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = a;
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if ({en1, we1, addr1, ready1} !== {1'b1, 1'b0, a, 1'b0}) begin
            fails++;
            $display("FAIL read_enable: en=%0b we=%0b addr=%h rdy=%0b, required 1 0 %h 0", en1, we1, addr1, ready1, a);
        end
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid1) begin
                cnt1++;
                if (lat1 < 0) begin lat1 = k; d1 = rsp_data1; end
            end
            if (rsp_valid3) begin
                cnt3++;
                if (lat3 < 0) begin lat3 = k; d3 = rsp_data3; end
            end
            @(negedge clk);
        end
        tests++;
        if (lat1 !== 2 || cnt1 !== 1) begin
            fails++;
            $display("FAIL read_lat1: latency=%0d valid_cycles=%0d, required 2 1", lat1, cnt1);
        end
        tests++;
        if (lat3 !== 4 || cnt3 !== 1) begin
            fails++;
            $display("FAIL read_lat3: latency=%0d valid_cycles=%0d, required 4 1", lat3, cnt3);
        end
        tests++;
        if (d1 !== ref_mem[a] || d3 !== ref_mem[a]) begin
            fails++;
            $display("FAIL read_data @%h: got %h / %h, required %h", a, d1, d3, ref_mem[a]);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op);
        wait_idle();
        cmd_valid = 1'b1; cmd_op = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == 2'b10) running = 1'b1;
        else begin running = 1'b0; err_m = 1'b0; end
        tests++;
        if ({cpu_rstn1, err1, ready1, cpu_rstn3, err3, en1} !== {running, err_m, 1'b1, running, err_m, 1'b0}) begin
            fails++;
            $display("FAIL cmd_%0d: cpu_rstn=%0b err=%0b rdy=%0b, required %0b %0b 1",
                     op, cpu_rstn1, err1, ready1, running, err_m);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({ready1, rsp_valid1, en1, we1, err1, cpu_rstn1, addr1, din1, rsp_data1, ready3, cpu_rstn3}
            !== {1'b1, 5'b0, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: rdy=%0b rv=%0b en=%0b we=%0b err=%0b cpu=%0b addr=%h din=%h rd=%h",
                     ready1, rsp_valid1, en1, we1, err1, cpu_rstn1, addr1, din1, rsp_data1);
        end
        rstn = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(9'h005, 32'hDEADBEEF);
        do_read(9'h005);
    endtask

    task automatic test_stall();
        logic [AW-1:0] a = 9'(100 + $urandom_range(0, 50));
        int n = 0;
        do_write(a, $urandom);
        wait_idle();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = a;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!(rsp_valid1 && rsp_valid3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!(rsp_valid1 && rsp_valid3)) begin
            fails++;
            $display("FAIL stall_wait: rv1=%0b rv3=%0b, required 1 1", rsp_valid1, rsp_valid3);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if ({rsp_valid1, rsp_data1, ready1, rsp_valid3, rsp_data3, ready3}
                !== {1'b1, ref_mem[a], 1'b0, 1'b1, ref_mem[a], 1'b0}) begin
                fails++;
                $display("FAIL stall_hold[%0d]: rv=%0b data=%h rdy=%0b, required 1 %h 0", k, rsp_valid1, rsp_data1, ready1, ref_mem[a]);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({rsp_valid1, ready1, rsp_valid3, ready3} !== 4'b0101) begin
            fails++;
            $display("FAIL stall_release: rv1=%0b rdy1=%0b rv3=%0b rdy3=%0b, required 0 1 0 1", rsp_valid1, ready1, rsp_valid3, ready3);
        end
    endtask

    task automatic test_run_halt();
        do_write(9'h010, 32'h0BADF00D);
        do_cmd(2'b10);
        do_cmd(2'b10);
        do_write(9'h010, 32'h12345678);
        do_read(9'h010);
        do_cmd(2'b11);
        do_cmd(2'b11);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] data [16];
        int n = 0;
        for (int i = 0; i < 16; i++) data[i] = $urandom;
        wait_idle();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = data[0];
        for (int t = 1; t <= 60 && n < 16; t++) begin
            @(negedge clk);
            if (we1) begin
                tests++;
                if ({addr1, din1, en1} !== {AW'(n), data[n], 1'b1} || t !== 2 * n + 1) begin
                    fails++;
                    $display("FAIL b2b_pulse[%0d]: addr=%h din=%h cycle=%0d, required %h %h %0d", n, addr1, din1, t, n, data[n], 2 * n + 1);
                end
                ref_mem[n] = data[n];
                written.push_back(n);
                n++;
                if (n < 16) begin
                    cmd_addr = AW'(n);
                    cmd_wdata = data[n];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        tests++;
        if (n !== 16) begin
            fails++;
            $display("FAIL b2b_count: pulses=%0d, required 16", n);
        end
        for (int i = 0; i < 16; i++) do_read(AW'(i));
    endtask

    task automatic test_reset_mid();
        int n = 0;
        // reset while in RD_WAIT
        do_cmd(2'b10);
        wait_idle();
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 9'h003;
        @(negedge clk);
        cmd_valid = 1'b0;
        rstn = 1'b0;
        #1;
        running = 1'b0; err_m = 1'b0;
        tests++;
        if ({rsp_valid1, cpu_rstn1, ready1, en1, rsp_valid3, cpu_rstn3, ready3} !== 7'b0010001) begin
            fails++;
            $display("FAIL rst_rdwait: rv=%0b cpu=%0b rdy=%0b en=%0b, required 0 0 1 0", rsp_valid1, cpu_rstn1, ready1, en1);
        end
        @(negedge clk);
        rstn = 1'b1;
        do_read(9'h003);
        // reset while in RESP
        do_cmd(2'b10);
        wait_idle();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 9'h007;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!rsp_valid1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        rstn = 1'b0;
        #1;
        running = 1'b0; err_m = 1'b0;
        tests++;
        if ({rsp_valid1, cpu_rstn1, ready1, rsp_valid3, cpu_rstn3, ready3} !== 6'b001001 || n >= 20) begin
            fails++;
            $display("FAIL rst_resp: rv=%0b cpu=%0b rdy=%0b wait=%0d, required 0 0 1", rsp_valid1, cpu_rstn1, ready1, n);
        end
        @(negedge clk);
        rstn = 1'b1;
        rsp_ready = 1'b1;
        do_read(9'h007);
        do_write(9'h1FF, 32'hA5A5_5A5A);
        do_read(9'h1FF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1: do_write(AW'($urandom_range(0, 511)), $urandom);
                2, 3: do_read(AW'(written[$urandom_range(0, written.size() - 1)]));
                4: do_cmd(2'b10);
                default: do_cmd(2'b11);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_stall();
        test_run_halt();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
